piso_tx8: RTL and testbench

PISO_TX8 -- requirements
Module: piso_tx8

---
 rtl/piso_tx8.sv | 103 ++++++++++
 tb/tb_piso_tx8.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx8.sv
// piso_tx8: parallel-in serial-out transmitter, MSB first.
// Optional build macro PISO_TX8_PARITY_EN appends an even-parity bit to each
// frame; with it undefined no parity logic exists and a frame is WIDTH bits.
module piso_tx8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef PISO_TX8_PARITY_EN
    localparam int unsigned F = WIDTH + 1;
`else
    localparam int unsigned F = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             last;
    logic             accept;
`ifdef PISO_TX8_PARITY_EN
    logic             par;
    logic             par_nx;
`endif

    // Next-state, datapath next values and outputs decoded from registers only.
    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        cnt_nx     = cnt;
`ifdef PISO_TX8_PARITY_EN
        par_nx     = par;
`endif
        last       = (state == SHIFT) && (cnt == LAST);
        ready      = (state == IDLE) || last;
        dout_valid = (state == SHIFT);
        done       = last;
        dout       = 1'b0;
        if (state == SHIFT) begin
`ifdef PISO_TX8_PARITY_EN
            dout = (cnt == CW'(WIDTH)) ? par : sreg[WIDTH-1];
`else
            dout = sreg[WIDTH-1];
`endif
        end

        accept = load && ready;
        if (accept) begin
            state_nx = SHIFT;
            sreg_nx  = din;
            cnt_nx   = '0;
`ifdef PISO_TX8_PARITY_EN
            par_nx   = ^din;
`endif
        end else if (state == SHIFT) begin
            if (last) begin
                state_nx = IDLE;
                sreg_nx  = '0;
                cnt_nx   = '0;
            end else begin
                sreg_nx = {sreg[WIDTH-2:0], 1'b0};
                cnt_nx  = cnt + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_TX8_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
`ifdef PISO_TX8_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx8.sv
// tb_piso_tx8: self-checking bench for piso_tx8 using a queue-based model of
// the serial stream (each accepted word appends its frame bits to a queue).
module tb_piso_tx8;

    localparam int unsigned W = 8;
`ifdef PISO_TX8_PARITY_EN
    localparam int unsigned F = W + 1;
`else
    localparam int unsigned F = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         load;
    logic         ready;
    logic         dout;
    logic         dout_valid;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bits still to be emitted; front is the bit on dout this cycle.
    logic q_bit[$];
    logic q_last[$];

    piso_tx8 #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load       (load),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected {ready, dout_valid, dout, done} for the current cycle.
    function automatic logic [3:0] exp_out();
        if (q_bit.size() == 0) return 4'b1000;
        return {q_bit.size() == 1, 1'b1, q_bit[0], q_last[0]};
    endfunction

    function automatic logic [3:0] act_out();
        return {ready, dout_valid, dout, done};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic l, input logic [W-1:0] d, input logic r);
        logic acc;
        @(negedge clk);
        load  = l;
        din   = d;
        reset = r;
        acc   = l && r && (q_bit.size() <= 1);
        @(posedge clk);
        if (!r) begin
            q_bit.delete();
            q_last.delete();
        end else begin
            if (q_bit.size() > 0) begin
                void'(q_bit.pop_front());
                void'(q_last.pop_front());
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) begin
                    q_bit.push_back(d[i]);
                    q_last.push_back((i == 0) && (F == W));
                end
                if (F != W) begin
                    q_bit.push_back(^d);
                    q_last.push_back(1'b1);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 8'hA5, 1'b0);
            n_checks++;
            if (act_out() !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b expected %b", c, act_out(), 4'b1000);
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (act_out() !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", c, act_out(), 4'b1000);
            end
        end
    endtask

    task automatic test_single_a5();
        logic [W-1:0] bits = '0;
        int ndone = 0;
        int done_cyc = -1;
        step(1'b1, 8'hA5, 1'b1);
        for (int c = 1; c <= F + 1; c++) begin
            n_checks++;
            if (act_out() !== exp_out()) begin
                n_fail++;
                $display("FAIL single_a5 cyc %0d: got %b expected %b", c, act_out(), exp_out());
            end
            if (c <= W) bits = {bits[W-2:0], dout};
            if (done) begin ndone++; done_cyc = c; end
            step(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (bits !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_a5_bits: got %h expected %h", bits, 8'hA5);
        end
        n_checks++;
        if (ndone != 1 || done_cyc != int'(F)) begin
            n_fail++;
            $display("FAIL single_a5_done: got %0d pulses at %0d expected 1 at %0d", ndone, done_cyc, F);
        end
    endtask

    task automatic test_parity();
        logic [W-1:0] words [2] = '{8'h07, 8'hA5};
        logic         pexp  [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            logic pbit = 1'b0;
            logic pdone = 1'b0;
            step(1'b1, words[k], 1'b1);
            for (int c = 1; c <= F; c++) begin
                n_checks++;
                if (act_out() !== exp_out()) begin
                    n_fail++;
                    $display("FAIL parity_%0d cyc %0d: got %b expected %b", k, c, act_out(), exp_out());
                end
                if (c == F) begin pbit = dout; pdone = done; end
                step(1'b0, 8'h00, 1'b1);
            end
`ifdef PISO_TX8_PARITY_EN
            n_checks++;
            if (pbit !== pexp[k] || pdone !== 1'b1) begin
                n_fail++;
                $display("FAIL parity_bit_%0d: got bit %b done %b expected bit %b done 1", k, pbit, pdone, pexp[k]);
            end
`else
            n_checks++;
            if (pbit !== words[k][0] || pdone !== 1'b1) begin
                n_fail++;
                $display("FAIL last_bit_%0d: got bit %b done %b expected bit %b done 1", k, pbit, pdone, words[k][0]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] bits = '0;
        int nvalid = 0;
        int d1 = -1;
        int d2 = -1;
        logic second = 1'b0;
        step(1'b1, 8'hA5, 1'b1);
        for (int c = 1; c <= 2 * F + 2; c++) begin
            logic l;
            n_checks++;
            if (act_out() !== exp_out()) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b expected %b", c, act_out(), exp_out());
            end
            if (dout_valid) begin
                nvalid++;
                if ((c <= W) || (c > F && c <= F + W)) bits = {bits[2*W-2:0], dout};
            end
            if (done) begin if (d1 < 0) d1 = c; else d2 = c; end
            l = !second && (q_bit.size() == 1);
            if (l) second = 1'b1;
            step(l, l ? 8'h3C : 8'h00, 1'b1);
        end
        n_checks++;
        if (bits !== 16'hA53C || nvalid != int'(2 * F)) begin
            n_fail++;
            $display("FAIL b2b_stream: got %h (%0d valid) expected a53c (%0d valid)", bits, nvalid, 2 * F);
        end
        n_checks++;
        if (d2 - d1 != int'(F) || d1 != int'(F)) begin
            n_fail++;
            $display("FAIL b2b_done: got pulses at %0d,%0d expected %0d,%0d", d1, d2, F, 2 * F);
        end
    endtask

    task automatic test_ignored_load();
        logic [W-1:0] bits = '0;
        step(1'b1, 8'hFF, 1'b1);
        for (int c = 1; c <= F + 1; c++) begin
            n_checks++;
            if (act_out() !== exp_out()) begin
                n_fail++;
                $display("FAIL ignored_load cyc %0d: got %b expected %b", c, act_out(), exp_out());
            end
            if (c <= W) bits = {bits[W-2:0], dout};
            step(c == 3, (c == 3) ? 8'h00 : 8'hFF, 1'b1);
        end
        n_checks++;
        if (bits !== 8'hFF) begin
            n_fail++;
            $display("FAIL ignored_load_bits: got %h expected ff", bits);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] bits = '0;
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (act_out() !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_mid_abort cyc %0d: got %b expected 1000", c, act_out());
            end
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b1, 8'h3C, 1'b1);
        for (int c = 1; c <= F + 1; c++) begin
            n_checks++;
            if (act_out() !== exp_out()) begin
                n_fail++;
                $display("FAIL reset_mid_reload cyc %0d: got %b expected %b", c, act_out(), exp_out());
            end
            if (c <= W) bits = {bits[W-2:0], dout};
            step(1'b0, $urandom_range(255, 0), 1'b1);
        end
        n_checks++;
        if (bits !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_mid_bits: got %h expected 3c", bits);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic l = ($urandom_range(99, 0) < 40);
            logic r = ($urandom_range(99, 0) >= 3);
            step(l, W'($urandom()), r);
            n_checks++;
            if (act_out() !== exp_out()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b expected %b", c, act_out(), exp_out());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        din   = '0;
        test_reset();
        test_single_a5();
        test_parity();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
